// File: rtl/wb_stage_mp_pkg.sv
// Shared widths, bus field offsets and default-width lane views for the
// multi-lane writeback stage.
package wb_stage_mp_pkg;

  localparam int LANES_DEF  = 2;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PC_W_DEF   = 32;
  localparam int STRB_W     = 4;

  // Bits per lane on ms_to_ws_bus: lane_v, pend, strobe, dest, result, pc.
  function automatic int lane_wd(input int addr_w, input int data_w, input int pc_w);
    return 2 + STRB_W + addr_w + data_w + pc_w;
  endfunction

  // Bits per lane on ws_to_rf_bus: we, waddr, wdata.
  function automatic int rf_lane_wd(input int addr_w, input int data_w);
    return STRB_W + addr_w + data_w;
  endfunction

  // Field offsets inside one lane of ms_to_ws_bus (pc sits at bit 0).
  function automatic int off_result(input int pc_w);
    return pc_w;
  endfunction

  function automatic int off_dest(input int data_w, input int pc_w);
    return pc_w + data_w;
  endfunction

  function automatic int off_strobe(input int addr_w, input int data_w, input int pc_w);
    return pc_w + data_w + addr_w;
  endfunction

  function automatic int off_pend(input int addr_w, input int data_w, input int pc_w);
    return lane_wd(addr_w, data_w, pc_w) - 2;
  endfunction

  function automatic int off_lane_v(input int addr_w, input int data_w, input int pc_w);
    return lane_wd(addr_w, data_w, pc_w) - 1;
  endfunction

  localparam int LANE_WD_DEF = lane_wd(ADDR_W_DEF, DATA_W_DEF, PC_W_DEF);
  localparam int MS_TO_WS_BUS_WD_DEF = LANES_DEF * LANE_WD_DEF;

  // Default-width view of one bus lane; packed MSB first to match the bus.
  typedef struct packed {
    logic                  lane_v;
    logic                  pend;
    logic [STRB_W-1:0]     strobe;
    logic [ADDR_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] result;
    logic [PC_W_DEF-1:0]   pc;
  } ws_lane_t;

  // Default-width view of one register-file write lane.
  typedef struct packed {
    logic [STRB_W-1:0]     we;
    logic [ADDR_W_DEF-1:0] waddr;
    logic [DATA_W_DEF-1:0] wdata;
  } ws_rf_lane_t;

endpackage

// File: rtl/wb_stage_mp_if.sv
// Memory-stage to writeback-stage bundle handshake.
// valid/ready: a bundle transfers on a rising edge where ms_to_ws_valid and
// ws_allowin are both high; the master holds bus stable while valid && !allowin,
// and ws_allowin never depends on ms_to_ws_valid.
interface wb_stage_mp_if
  import wb_stage_mp_pkg::*;
#(
  parameter int BUS_W = MS_TO_WS_BUS_WD_DEF
) ();

  logic             ms_to_ws_valid;
  logic [BUS_W-1:0] ms_to_ws_bus;
  logic             ws_allowin;

  modport master (
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    output ws_allowin
  );

endinterface

// File: rtl/wb_stage_mp_lane_slot.sv
// One lane of the writeback bundle: holds the lane fields, its pending and
// done bits, captures an early late result, and produces its rf-write and
// forwarding fields.
module wb_lane_slot
  import wb_stage_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  localparam int LANE_WD = lane_wd(ADDR_W, DATA_W, PC_W),
  localparam int RF_WD   = rf_lane_wd(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ws_valid,
  input  logic               load,
  input  logic [LANE_WD-1:0] lane_in,
  input  logic               commit,
  input  logic               late_store,
  input  logic [DATA_W-1:0]  late_data,
  output logic               lane_v,
  output logic               pend,
  output logic               done,
  output logic [STRB_W-1:0]  strobe,
  output logic [ADDR_W-1:0]  dest,
  output logic [DATA_W-1:0]  result,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  commit_data,
  output logic [RF_WD-1:0]   rf_lane,
  output logic [ADDR_W-1:0]  real_dest,
  output logic               fwd_pending
);

  logic              v_in;
  logic              pend_in;
  logic [STRB_W-1:0] strobe_in;
  logic [ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0] result_in;
  logic [PC_W-1:0]   pc_in;
  logic              live;

  assign v_in      = lane_in[off_lane_v(ADDR_W, DATA_W, PC_W)];
  assign pend_in   = lane_in[off_pend(ADDR_W, DATA_W, PC_W)];
  assign strobe_in = lane_in[off_strobe(ADDR_W, DATA_W, PC_W) +: STRB_W];
  assign dest_in   = lane_in[off_dest(DATA_W, PC_W) +: ADDR_W];
  assign result_in = lane_in[off_result(PC_W) +: DATA_W];
  assign pc_in     = lane_in[PC_W-1:0];

  // Lane register: a new bundle overrides everything; otherwise a commit
  // retires the lane and an early late result fills the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_v <= 1'b0;
      pend   <= 1'b0;
      done   <= 1'b0;
      strobe <= '0;
      dest   <= '0;
      result <= '0;
      pc     <= '0;
    end else if (load) begin
      lane_v <= v_in;
      pend   <= pend_in & v_in;
      done   <= 1'b0;
      strobe <= strobe_in;
      dest   <= dest_in;
      result <= result_in;
      pc     <= pc_in;
    end else if (commit) begin
      done <= 1'b1;
      pend <= 1'b0;
      if (pend) result <= late_data;
    end else if (late_store) begin
      pend   <= 1'b0;
      result <= late_data;
    end
  end

  // A pending lane can only commit alongside late_valid, so its data is the
  // late value bypassed in the same cycle.
  assign commit_data = pend ? late_data : result;
  assign rf_lane     = {(commit ? strobe : {STRB_W{1'b0}}), dest, commit_data};

  // A lane is a forwarding hazard until it has retired a non-empty write.
  assign live        = ws_valid & lane_v & ~done & (strobe != '0);
  assign real_dest   = live ? dest : '0;
  assign fwd_pending = live & pend;

endmodule

// File: rtl/wb_stage_mp.sv
// Multi-lane writeback stage: retires up to LANES instructions per bundle in
// program order, one lane per cycle, with late-result bypass, debug trace,
// per-lane forwarding and a retired-instruction counter.
module wb_stage_mp
  import wb_stage_mp_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  localparam int LANE_WD = lane_wd(ADDR_W, DATA_W, PC_W),
  localparam int RF_WD   = rf_lane_wd(ADDR_W, DATA_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  wb_stage_mp_if.slave              ms_ws,
  input  logic                      late_valid,
  input  logic [DATA_W-1:0]         late_data,
  output logic [LANES*RF_WD-1:0]    ws_to_rf_bus,
  output logic [PC_W-1:0]           debug_wb_pc,
  output logic [STRB_W-1:0]         debug_wb_rf_wen,
  output logic [ADDR_W-1:0]         debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata,
  output logic [LANES*ADDR_W-1:0]   ws_real_dest,
  output logic [LANES*DATA_W-1:0]   wb_forward_data,
  output logic [LANES-1:0]          ws_fwd_pending,
  output logic [31:0]               ws_retire_cnt
);

  logic              ws_valid;
  logic              allowin;
  logic              accept;

  logic [LANES-1:0]  lane_v;
  logic [LANES-1:0]  pend;
  logic [LANES-1:0]  done;
  logic [STRB_W-1:0] strobe      [LANES];
  logic [ADDR_W-1:0] dest        [LANES];
  logic [DATA_W-1:0] result      [LANES];
  logic [PC_W-1:0]   pc          [LANES];
  logic [DATA_W-1:0] commit_data [LANES];
  logic [RF_WD-1:0]  rf_lane     [LANES];
  logic [ADDR_W-1:0] real_dest   [LANES];

  logic [LANES-1:0]  active;
  logic [LANES-1:0]  pend_live;
  logic [LANES-1:0]  cur_oh;
  logic [LANES-1:0]  pend_oh;
  logic              seen_act;
  logic              seen_pend;
  logic              cur_pend;
  logic              commit;
  logic              late_store;
  logic              ready_go;

  // Lane selection: cur is the oldest unretired valid lane, and a late result
  // always belongs to the oldest pending lane.
  always_comb begin
    active    = ws_valid ? (lane_v & ~done) : '0;
    pend_live = ws_valid ? pend : '0;
    cur_oh    = '0;
    pend_oh   = '0;
    seen_act  = 1'b0;
    seen_pend = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (active[i] && !seen_act) cur_oh[i] = 1'b1;
      if (pend_live[i] && !seen_pend) pend_oh[i] = 1'b1;
      seen_act  = seen_act | active[i];
      seen_pend = seen_pend | pend_live[i];
    end
    cur_pend   = |(cur_oh & pend_live);
    commit     = seen_act && (!cur_pend || late_valid);
    late_store = late_valid && seen_pend && !cur_pend;
    ready_go   = !seen_act || (((active & ~cur_oh) == '0) && commit);
  end

  assign allowin          = !ws_valid || ready_go;
  assign ms_ws.ws_allowin = allowin;
  assign accept           = ms_ws.ms_to_ws_valid && allowin;

  // Bundle valid: replaced whenever the stage can take a new bundle.
  always_ff @(posedge clk) begin
    if (reset) ws_valid <= 1'b0;
    else if (allowin) ws_valid <= ms_ws.ms_to_ws_valid;
  end

  // Retired-instruction counter, one per committed lane, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) ws_retire_cnt <= '0;
    else if (commit) ws_retire_cnt <= ws_retire_cnt + 32'd1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wb_lane_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PC_W   (PC_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .ws_valid    (ws_valid),
      .load        (accept),
      .lane_in     (ms_ws.ms_to_ws_bus[g*LANE_WD +: LANE_WD]),
      .commit      (commit & cur_oh[g]),
      .late_store  (late_store & pend_oh[g]),
      .late_data   (late_data),
      .lane_v      (lane_v[g]),
      .pend        (pend[g]),
      .done        (done[g]),
      .strobe      (strobe[g]),
      .dest        (dest[g]),
      .result      (result[g]),
      .pc          (pc[g]),
      .commit_data (commit_data[g]),
      .rf_lane     (rf_lane[g]),
      .real_dest   (real_dest[g]),
      .fwd_pending (ws_fwd_pending[g])
    );

    assign ws_to_rf_bus[g*RF_WD +: RF_WD]     = rf_lane[g];
    assign ws_real_dest[g*ADDR_W +: ADDR_W]   = real_dest[g];
    assign wb_forward_data[g*DATA_W +: DATA_W] = result[g];
  end

  // Debug trace follows the committing lane and reads all zero otherwise.
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (cur_oh[i]) begin
          debug_wb_pc       = pc[i];
          debug_wb_rf_wen   = strobe[i];
          debug_wb_rf_wnum  = dest[i];
          debug_wb_rf_wdata = commit_data[i];
        end
      end
    end
  end

endmodule
